result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector_if.sv | 27 ++
 rtl/result_collector.sv | 142 ++++++++++++++
 tb/tb_result_collector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/result_collector_if.sv
// Result-collector bus: array result stream in, drained result bytes and status out.
// The slave modport is the collector; the master modport is its environment.
interface result_collector_if #(
  parameter int unsigned W = 8
) ();
  logic         clr;
  logic         ack_in;
  logic [W-1:0] data_in;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         done;
  logic         err_short;
  logic         overrun;

  modport slave (
    input  clr, ack_in, data_in, out_ready,
    output out_data, out_valid, out_idx, out_last, done, err_short, overrun
  );

  modport master (
    output clr, ack_in, data_in, out_ready,
    input  out_data, out_valid, out_idx, out_last, done, err_short, overrun
  );
endinterface

// File: rtl/result_collector.sv
// Captures one NBYTES result matrix from the array shift-out stream and drains it
// byte by byte over a valid/ready port, flagging short streams and dropped bytes.
module result_collector #(
  parameter int unsigned W      = 8,
  parameter int unsigned NBYTES = 16
) (
  input  logic              clk,
  input  logic              rst,
  result_collector_if.slave bus
);
  localparam int unsigned CW = $clog2(NBYTES + 1);
  localparam int unsigned AW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] WCNT_MAX  = CW'(NBYTES);
  localparam logic [CW-1:0] WCNT_LAST = CW'(NBYTES - 1);
  localparam logic [AW-1:0] RPTR_LAST = AW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          done_q, done_d;
  logic          err_short_q, err_short_d;
  logic          overrun_q, overrun_d;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  mem_q [NBYTES];

  // State and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rptr_q      <= '0;
      done_q      <= 1'b0;
      err_short_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rptr_q      <= rptr_d;
      done_q      <= done_d;
      err_short_q <= err_short_d;
      overrun_q   <= overrun_d;
    end
  end

  // Result buffer; contents only ever leave the block during DRAIN, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= bus.data_in;
    end
  end

  // Next-state and buffer-write control.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rptr_d      = rptr_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
    err_short_d = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;

    if (bus.clr) begin
      state_d   = IDLE;
      wcnt_d    = '0;
      rptr_d    = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.ack_in) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wcnt_d  = CW'(1);
            rptr_d  = '0;
            state_d = (NBYTES == 1) ? DRAIN : CAPTURE;
          end
        end

        CAPTURE: begin
          if (bus.ack_in) begin
            wr_en   = (wcnt_q < WCNT_MAX);
            wr_addr = AW'(wcnt_q);
            if (wcnt_q < WCNT_MAX) begin
              wcnt_d = wcnt_q + CW'(1);
            end
            if (wcnt_q == WCNT_LAST) begin
              state_d = DRAIN;
              rptr_d  = '0;
            end
          end else begin
            // Stream stopped before the matrix was complete: discard it.
            err_short_d = 1'b1;
            wcnt_d      = '0;
            state_d     = IDLE;
          end
        end

        DRAIN: begin
          if (bus.ack_in) begin
            overrun_d = 1'b1;
          end
          if (bus.out_ready) begin
            if (rptr_q == RPTR_LAST) begin
              state_d = IDLE;
              done_d  = 1'b1;
              rptr_d  = '0;
              wcnt_d  = '0;
            end else begin
              rptr_d = rptr_q + AW'(1);
            end
          end
        end

        default: begin
          state_d = IDLE;
          wcnt_d  = '0;
          rptr_d  = '0;
        end
      endcase
    end
  end

  // Drain port is decoded straight from registered state.
  logic draining;
  assign draining      = (state_q == DRAIN);
  assign bus.out_valid = draining;
  assign bus.out_data  = draining ? mem_q[rptr_q] : '0;
  assign bus.out_idx   = draining ? 4'(rptr_q) : 4'd0;
  assign bus.out_last  = draining && (rptr_q == RPTR_LAST);
  assign bus.done      = done_q;
  assign bus.err_short = err_short_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_result_collector.sv
// Directed + randomized bench for result_collector with a queue-based expected-byte model.
module tb_result_collector;
  localparam int unsigned W  = 8;
  localparam int unsigned NB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  result_collector_if #(.W(W)) bus ();

  result_collector #(.W(W), .NBYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q [$];
  logic         ovr_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},   32'(bus.out_valid), 0);
    chk({tag, "_data"},    32'(bus.out_data),  0);
    chk({tag, "_idx"},     32'(bus.out_idx),   0);
    chk({tag, "_last"},    32'(bus.out_last),  0);
    chk({tag, "_done"},    32'(bus.done),      0);
    chk({tag, "_err"},     32'(bus.err_short), 0);
    chk({tag, "_overrun"}, 32'(bus.overrun),   0);
  endtask

  // Feed n bytes on consecutive cycles; the model records what should come back.
  task automatic capture(input int n, input bit rnd, input logic [W-1:0] base);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      bus.ack_in  = 1'b1;
      bus.data_in = rnd ? W'($urandom) : base + W'(i);
      exp_q.push_back(bus.data_in);
      tick();
      if (i == NB - 1) begin
        chk("latency_valid", 32'(bus.out_valid), 1);
        chk("latency_idx",   32'(bus.out_idx),   0);
      end else begin
        chk("capture_novalid", 32'(bus.out_valid), 0);
        chk("capture_noerr",   32'(bus.err_short), 0);
      end
    end
    bus.ack_in = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready.
  task automatic drain(input int mode, input int n_ovr, input int stop_after);
    int k = 0;
    int cyc = 0;
    logic rdy = 1'b1;
    logic [W-1:0] prev_data = '0;
    while (k < stop_after && cyc < 400) begin
      chk("drain_valid",   32'(bus.out_valid), 1);
      chk("drain_idx",     32'(bus.out_idx),   32'(k));
      chk("drain_data",    32'(bus.out_data),  32'(exp_q[k]));
      chk("drain_last",    32'(bus.out_last),  32'(k == NB - 1));
      chk("drain_done",    32'(bus.done),      0);
      chk("drain_overrun", 32'(bus.overrun),   32'(ovr_exp));
      if (cyc > 0 && !rdy) begin
        chk("stall_stable", 32'(bus.out_data), 32'(prev_data));
      end
      prev_data = bus.out_data;
      if (cyc < n_ovr) begin
        rdy         = 1'b0;
        bus.ack_in  = 1'b1;
        bus.data_in = 8'hAA;
      end else begin
        bus.ack_in = 1'b0;
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ((cyc % 3) == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
      end
      bus.out_ready = rdy;
      tick();
      if (bus.ack_in) ovr_exp = 1'b1;
      if (rdy) k++;
      cyc++;
    end
    bus.ack_in    = 1'b0;
    bus.out_ready = 1'b0;
    if (k < stop_after) begin
      chk("drain_timeout", 32'(k), 32'(stop_after));
    end else if (stop_after == NB) begin
      chk("done_pulse",   32'(bus.done),      1);
      chk("post_valid",   32'(bus.out_valid), 0);
      chk("post_overrun", 32'(bus.overrun),   32'(ovr_exp));
      tick();
      chk("done_clear",   32'(bus.done),      0);
      chk("idle_valid",   32'(bus.out_valid), 0);
    end
  endtask

  initial begin
    bus.clr = 1'b0; bus.ack_in = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    repeat (2) tick();
    @(negedge clk) rst = 1'b0;
    tick();
    chk_all_zero("after_reset");

    // Nominal 0x01..0x10, always ready
    capture(NB, 1'b0, 8'h01);
    drain(0, 0, NB);

    // Backpressure 1,0,0,...
    capture(NB, 1'b0, 8'h01);
    drain(1, 0, NB);

    // Random data, random backpressure
    for (int r = 0; r < 4; r++) begin
      capture(NB, 1'b1, '0);
      drain(2, 0, NB);
    end

    // Short stream: 9 bytes then ack drops
    capture(9, 1'b1, '0);
    tick();
    chk("short_err_pulse", 32'(bus.err_short), 1);
    chk("short_novalid",   32'(bus.out_valid), 0);
    tick();
    chk("short_err_clear", 32'(bus.err_short), 0);
    chk("short_idle",      32'(bus.out_valid), 0);
    capture(NB, 1'b1, '0);
    drain(0, 0, NB);

    // Overrun: 3 extra 0xAA bytes while stalled
    capture(NB, 1'b0, 8'h01);
    drain(0, 3, NB);
    chk("overrun_sticky", 32'(bus.overrun), 1);
    capture(NB, 1'b1, '0);
    drain(2, 0, NB);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    ovr_exp = 1'b0;
    chk("overrun_cleared", 32'(bus.overrun), 0);

    // Async reset after 5 bytes accepted
    capture(NB, 1'b0, 8'h01);
    drain(0, 0, 5);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_drain_rst");
    @(negedge clk) rst = 1'b0;
    tick();
    capture(NB, 1'b0, 8'h21);
    drain(0, 0, NB);

    // clr with ack_in in IDLE: byte must not be stored
    bus.clr = 1'b1; bus.ack_in = 1'b1; bus.data_in = 8'h55;
    tick();
    bus.clr = 1'b0; bus.ack_in = 1'b0;
    chk("clr_idle_valid", 32'(bus.out_valid), 0);
    tick();
    chk("clr_idle_noerr", 32'(bus.err_short), 0);
    capture(NB, 1'b1, '0);
    drain(0, 0, NB);

    // clr during drain wins over an accepted handshake
    capture(NB, 1'b1, '0);
    drain(0, 0, 3);
    bus.clr = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.clr = 1'b0; bus.out_ready = 1'b0;
    chk("clr_drain_valid", 32'(bus.out_valid), 0);
    chk("clr_drain_done",  32'(bus.done),      0);
    capture(NB, 1'b1, '0);
    drain(1, 0, NB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
